// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core's load/store path
// (master) and a data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, executes on an internal little-endian word array and returns read
// data plus an error flag.
// Optional feature macro: DMEM_PERF_CNT_EN adds saturating 16-bit
// rd_count / wr_count / err_count outputs.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       err_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ADDR_LIMIT_I = 4 * DEPTH;
  localparam logic [ADDR_W:0] ADDR_LIMIT = ADDR_LIMIT_I[ADDR_W:0];
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Any rule violation rejects the request without touching storage.
  function automatic logic req_error(input logic wr, input logic [ADDR_W-1:0] addr,
                                     input logic [2:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_BU:   bad = wr;
      SZ_H:    bad = addr[0];
      SZ_HU:   bad = wr | addr[0];
      SZ_W:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    bad = bad | ({1'b0, addr} >= ADDR_LIMIT);
    return bad;
  endfunction

  // Select the addressed byte/half of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] size);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    res = {{24{byte_v[7]}}, byte_v};
      SZ_BU:   res = {24'd0, byte_v};
      SZ_H:    res = {{16{half_v[15]}}, half_v};
      SZ_HU:   res = {16'd0, half_v};
      SZ_W:    res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Byte enables of a store within its word.
  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] size);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate LSB-aligned store data across every lane it may land in.
  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [2:0] size);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        wait_cnt_r;
  logic              exec_s;

  logic              lat_write_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [2:0]        lat_size_r;
  logic [31:0]       lat_wdata_r;

  logic              ex_write_s;
  logic [ADDR_W-1:0] ex_addr_s;
  logic [2:0]        ex_size_s;
  logic [31:0]       ex_wdata_s;

  logic              ex_err_s;
  logic [IDX_W-1:0]  ex_idx_s;
  logic [1:0]        ex_lane_s;
  logic [31:0]       ex_word_s;
  logic [31:0]       ex_load_s;
  logic [3:0]        ex_be_s;
  logic [31:0]       ex_sdata_s;

  logic [31:0]       mem_r [DEPTH];

  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  // Next-state decode; exec_s marks the edge on which the access happens.
  always_comb begin
    state_nxt_s = state_r;
    exec_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_STATES > 0) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_RESP;
            exec_s      = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_RESP;
          exec_s      = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Zero wait states execute straight from the bus; otherwise use the latched copy.
  always_comb begin
    ex_write_s = lat_write_r;
    ex_addr_s  = lat_addr_r;
    ex_size_s  = lat_size_r;
    ex_wdata_s = lat_wdata_r;
    if (state_r == ST_IDLE) begin
      ex_write_s = bus.req_write;
      ex_addr_s  = bus.req_addr;
      ex_size_s  = bus.req_size;
      ex_wdata_s = bus.req_wdata;
    end else begin
      ex_write_s = lat_write_r;
      ex_addr_s  = lat_addr_r;
      ex_size_s  = lat_size_r;
      ex_wdata_s = lat_wdata_r;
    end
  end

  // Decode of the executing access: error, word index, lane, load and store data.
  always_comb begin
    ex_err_s   = req_error(ex_write_s, ex_addr_s, ex_size_s);
    ex_idx_s   = ex_addr_s[IDX_W+1:2];
    ex_lane_s  = ex_addr_s[1:0];
    ex_word_s  = mem_r[ex_idx_s];
    ex_load_s  = load_extend(ex_word_s, ex_lane_s, ex_size_s);
    ex_be_s    = store_be(ex_lane_s, ex_size_s);
    ex_sdata_s = store_data(ex_wdata_s, ex_size_s);
  end

  // FSM state register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= 4'd0;
      end
    end
  end

  // Capture the request on the accept handshake only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_write_r <= 1'b0;
      lat_addr_r  <= '0;
      lat_size_r  <= 3'd0;
      lat_wdata_r <= 32'd0;
    end else if (state_r == ST_IDLE && bus.req_valid) begin
      lat_write_r <= bus.req_write;
      lat_addr_r  <= bus.req_addr;
      lat_size_r  <= bus.req_size;
      lat_wdata_r <= bus.req_wdata;
    end
  end

  // Registered handshake flags and response payload, updated on the execute edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      if (exec_s) begin
        rsp_err_r   <= ex_err_s;
        rsp_rdata_r <= (ex_err_s || ex_write_s) ? 32'd0 : ex_load_s;
      end
    end
  end

  // Word storage: cleared by reset, byte-masked store on a clean execute edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (exec_s && ex_write_s && !ex_err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ex_be_s[b]) begin
          mem_r[ex_idx_s][8*b +: 8] <= ex_sdata_s[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;
  logic [15:0] err_cnt_r;

  assign rd_count  = rd_cnt_r;
  assign wr_count  = wr_cnt_r;
  assign err_count = err_cnt_r;

  // Saturating event counters sampled on the execute edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_r  <= 16'd0;
      wr_cnt_r  <= 16'd0;
      err_cnt_r <= 16'd0;
    end else if (exec_s) begin
      if (ex_err_s) begin
        if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
      end else if (ex_write_s) begin
        if (wr_cnt_r != 16'hFFFF) wr_cnt_r <= wr_cnt_r + 16'd1;
      end else begin
        if (rd_cnt_r != 16'hFFFF) rd_cnt_r <= rd_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: DUT "a" (DEPTH=64, ADDR_W=9, 1 wait state) and DUT "b"
// (DEPTH=64, ADDR_W=8, 0 wait states) checked against a byte-array model.
module tb_dmem_responder;

  localparam int WS_A = 1;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] mb [2][256];

  dmem_responder_if #(.ADDR_W(9)) ia ();
  dmem_responder_if #(.ADDR_W(8)) ib ();

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_a, wr_a, err_a, rd_b, wr_b, err_b;
`endif

  dmem_responder #(.DEPTH(64), .ADDR_W(9), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rd_a), .wr_count(wr_a), .err_count(err_a)
`endif
  );

  dmem_responder #(.DEPTH(64), .ADDR_W(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rd_b), .wr_count(wr_b), .err_count(err_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic void clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) mb[w][i] = 8'd0;
  endfunction

  // Reference: storage viewed as 256 little-endian bytes per DUT.
  function automatic void model_exec(input int which, input logic wr, input int addr,
                                     input logic [2:0] size, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] v;
    n = (size[1:0] == 2'b00) ? 1 : ((size[1:0] == 2'b01) ? 2 : 4);
    err = (size == 3'b011) || (size == 3'b110) || (size == 3'b111) ||
          (wr && (size == SZ_BU || size == SZ_HU)) || (addr % n != 0) || (addr >= 256);
    rdata = 32'd0;
    v = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mb[which][addr + i] = wdata[8*i +: 8];
        else v[8*i +: 8] = mb[which][addr + i];
      end
      if (!wr) begin
        if (size[2] == 1'b0 && n < 4 && v[8*n - 1] == 1'b1) v = v | (32'hFFFF_FFFF << (8*n));
        rdata = v;
      end
    end
  endfunction

  // One complete transaction on DUT a with rsp_ready held high.
  task automatic txn_a(input logic wr, input logic [8:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input string name);
    int lat;
    bit ready_low;
    logic [31:0] exp_d;
    logic exp_e;
    @(negedge clk);
    ia.rsp_ready = 1'b1;
    checks++;
    if (ia.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready got %b want 1", name, ia.req_ready);
    end
    ia.req_valid = 1'b1; ia.req_write = wr; ia.req_addr = addr;
    ia.req_size = size; ia.req_wdata = wdata;
    @(posedge clk); #1;
    ia.req_valid = 1'b0; ia.req_write = 1'($urandom); ia.req_addr = 9'($urandom);
    ia.req_size = 3'($urandom); ia.req_wdata = $urandom;
    model_exec(0, wr, int'(addr), size, wdata, exp_d, exp_e);
    lat = 0; ready_low = 1'b1;
    do begin
      @(negedge clk); lat++;
      if (ia.req_ready !== 1'b0) ready_low = 1'b0;
    end while (ia.rsp_valid !== 1'b1 && lat < 40);
    checks++;
    if (lat != WS_A + 1 || ia.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, WS_A + 1);
    end
    checks++;
    if (!ready_low) begin errors++; $display("FAIL %s ready_low_while_busy got 0 want 1", name); end
    checks++;
    if (ia.rsp_err !== exp_e) begin
      errors++; $display("FAIL %s err addr=%h size=%b got %b want %b", name, addr, size, ia.rsp_err, exp_e);
    end
    checks++;
    if (ia.rsp_rdata !== exp_d) begin
      errors++; $display("FAIL %s rdata addr=%h size=%b got %h want %h", name, addr, size, ia.rsp_rdata, exp_d);
    end
    @(negedge clk);
    checks++;
    if (ia.rsp_valid !== 1'b0 || ia.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s release got valid=%b ready=%b want 0/1", name, ia.rsp_valid, ia.req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ia.req_ready !== 1'b1 || ib.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b want 1/1", ia.req_ready, ib.req_ready);
    end
    checks++;
    if (ia.rsp_valid !== 1'b0 || ib.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b/%b want 0/0", ia.rsp_valid, ib.rsp_valid);
    end
    checks++;
    if (ia.rsp_rdata !== 32'd0 || ia.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_payload got %h/%b want 0/0", ia.rsp_rdata, ia.rsp_err);
    end
`ifdef DMEM_PERF_CNT_EN
    checks++;
    if (rd_a !== 16'd0 || wr_a !== 16'd0 || err_a !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %h %h %h want 0 0 0", rd_a, wr_a, err_a);
    end
`endif
    reset = 1'b1;
    clear_model();
  endtask

  task automatic test_back_to_back();
    logic        wr [6];
    logic [7:0]  ad [6];
    logic [2:0]  sz [6];
    logic [31:0] wd [6];
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    logic [31:0] d;
    logic        e;
    logic        want_ready;
    int idx;
    int accepts;
    wr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ad = '{8'h04, 8'h0A, 8'h04, 8'h0A, 8'h0B, 8'h06};
    sz = '{SZ_W, SZ_H, SZ_W, SZ_HU, SZ_B, SZ_W};
    for (int i = 0; i < 6; i++) wd[i] = $urandom;
    idx = 0; accepts = 0;
    @(negedge clk);
    ib.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 6) begin
        ib.req_valid = 1'b1; ib.req_write = wr[idx]; ib.req_addr = ad[idx];
        ib.req_size = sz[idx]; ib.req_wdata = wd[idx];
      end else begin
        ib.req_valid = 1'b0;
      end
      want_ready = (cyc % 2 == 0);
      checks++;
      if (ib.req_ready !== want_ready || ib.rsp_valid !== ~want_ready) begin
        errors++; $display("FAIL b2b_pattern cyc=%0d got ready=%b valid=%b want %b/%b",
                           cyc, ib.req_ready, ib.rsp_valid, want_ready, ~want_ready);
      end
      if (ib.rsp_valid === 1'b1) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++; $display("FAIL b2b_extra_rsp cyc=%0d got response want none", cyc);
        end else begin
          d = exp_d.pop_front(); e = exp_e.pop_front();
          if (ib.rsp_rdata !== d || ib.rsp_err !== e) begin
            errors++; $display("FAIL b2b_rsp cyc=%0d got %h/%b want %h/%b", cyc, ib.rsp_rdata, ib.rsp_err, d, e);
          end
        end
      end
      if (ib.req_ready === 1'b1 && idx < 6) begin
        model_exec(1, wr[idx], int'(ad[idx]), sz[idx], wd[idx], d, e);
        exp_d.push_back(d); exp_e.push_back(e);
        idx++; accepts++;
      end
      @(negedge clk);
    end
    ib.req_valid = 1'b0;
    checks++;
    if (accepts != 6 || exp_d.size() != 0) begin
      errors++; $display("FAIL b2b_throughput got %0d accepts %0d pending want 6/0", accepts, exp_d.size());
    end
`ifdef DMEM_PERF_CNT_EN
    checks++;
    if (rd_b !== 16'd3 || wr_b !== 16'd2 || err_b !== 16'd1) begin
      errors++; $display("FAIL perf_counters got %0d %0d %0d want 3 2 1", rd_b, wr_b, err_b);
    end
`endif
  endtask

  task automatic test_store_load();
    txn_a(1'b1, 9'h010, SZ_W, 32'hDEADBEEF, "store_w");
    txn_a(1'b0, 9'h010, SZ_W, 32'd0, "load_w");
  endtask

  task automatic test_byte_lanes();
    txn_a(1'b1, 9'h012, SZ_B, 32'h0000005A, "store_b");
    txn_a(1'b0, 9'h010, SZ_W, 32'd0, "lane_w");
    txn_a(1'b0, 9'h013, SZ_B, 32'd0, "lane_b");
    txn_a(1'b0, 9'h013, SZ_BU, 32'd0, "lane_bu");
    txn_a(1'b0, 9'h012, SZ_H, 32'd0, "lane_h");
  endtask

  task automatic test_errors();
    txn_a(1'b0, 9'h011, SZ_W, 32'd0, "err_misaligned_w");
    txn_a(1'b1, 9'h013, SZ_H, 32'h0000FFFF, "err_misaligned_h");
    txn_a(1'b0, 9'h010, 3'b011, 32'd0, "err_size");
    txn_a(1'b1, 9'h010, SZ_BU, 32'h12345678, "err_store_bu");
    txn_a(1'b0, 9'h100, SZ_W, 32'd0, "err_range");
    txn_a(1'b0, 9'h010, SZ_W, 32'd0, "err_untouched");
  endtask

  task automatic test_stall();
    logic [31:0] exp_d;
    logic exp_e;
    logic [31:0] held;
    int lat;
    bit stable;
    @(negedge clk);
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1; ia.req_write = 1'b0; ia.req_addr = 9'h010;
    ia.req_size = SZ_W; ia.req_wdata = 32'd0;
    @(posedge clk); #1;
    ia.req_valid = 1'b0;
    model_exec(0, 1'b0, 16, SZ_W, 32'd0, exp_d, exp_e);
    lat = 0;
    do begin @(negedge clk); lat++; end while (ia.rsp_valid !== 1'b1 && lat < 40);
    held = ia.rsp_rdata;
    checks++;
    if (ia.rsp_valid !== 1'b1 || held !== exp_d) begin
      errors++; $display("FAIL stall_first got %b/%h want 1/%h", ia.rsp_valid, held, exp_d);
    end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ia.req_valid = (k % 2 == 0); ia.req_write = 1'b1; ia.req_addr = 9'h030;
      ia.req_size = SZ_W; ia.req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== held || ia.rsp_err !== exp_e ||
          ia.req_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL stall_stable got 0 want 1"); end
    ia.req_valid = 1'b0;
    ia.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ia.rsp_valid !== 1'b0 || ia.req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got %b/%b want 0/1", ia.rsp_valid, ia.req_ready);
    end
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ia.rsp_valid !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL stall_phantom got response want none"); end
    txn_a(1'b0, 9'h030, SZ_W, 32'd0, "stall_ignored_store");
  endtask

  task automatic test_reset_mid();
    bit saw;
    @(negedge clk);
    ia.rsp_ready = 1'b1;
    ia.req_valid = 1'b1; ia.req_write = 1'b1; ia.req_addr = 9'h020;
    ia.req_size = SZ_W; ia.req_wdata = 32'h11111111;
    @(posedge clk); #1;
    ia.req_valid = 1'b0;
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ia.rsp_valid !== 1'b0) saw = 1'b1;
      if (k == 1) reset = 1'b1;
    end
    clear_model();
    checks++;
    if (saw || ia.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got valid_seen=%b ready=%b want 0/1", saw, ia.req_ready);
    end
    txn_a(1'b0, 9'h020, SZ_W, 32'd0, "reset_mid_load");
  endtask

  task automatic test_random();
    logic [8:0] a;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 79));
      txn_a(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, "random");
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; checks = 0; errors = 0;
    ia.req_valid = 1'b0; ia.req_write = 1'b0; ia.req_addr = '0; ia.req_size = 3'd0;
    ia.req_wdata = 32'd0; ia.rsp_ready = 1'b1;
    ib.req_valid = 1'b0; ib.req_write = 1'b0; ib.req_addr = '0; ib.req_size = 3'd0;
    ib.req_wdata = 32'd0; ib.rsp_ready = 1'b1;
    clear_model();
    test_reset();
    test_back_to_back();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the core's load/store data-memory interface.
- Accepts one valid/ready request at a time: byte, half or word, load or store.
- Inserts a configurable number of wait states, performs the access on an internal word array, and returns a response with read data and an error flag.
- Sits between the core's load/store path and data storage; replaces the zero-latency data memory once the core moves to a stalling memory interface.

Parameters:
- DEPTH, 64: number of 32-bit words in storage; byte address range 0 .. 4*DEPTH-1.
- ADDR_W, 8: byte address width; 4*DEPTH must be <= 2^ADDR_W.
- WAIT_STATES, 1: idle cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_size  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request rejected (misaligned, illegal size, out of range).

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Wait counter=0; all storage words cleared to 0.
- FSM states:
  - IDLE: req_ready=1. Handshake req_valid&req_ready latches write, addr, size and wdata.
    - Next state is WAIT if WAIT_STATES>0, else EXEC behaviour folds into the accept edge and next state is RESP.
  - WAIT: req_ready=0. Counter counts up; after WAIT_STATES cycles in WAIT, the access executes on the exiting edge and the FSM moves to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err stable. On rsp_valid&rsp_ready → IDLE; rsp_valid drops next cycle.
- Latency: acceptance edge to rsp_valid high = WAIT_STATES+1 cycles.
- Throughput: one request per WAIT_STATES+2 cycles at best; req_ready is never high in the same cycle as rsp_valid.
- Error checks (any one sets rsp_err=1, rsp_rdata=0, storage untouched):
  - size 011/110/111;
  - store with size 100 or 101;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= 4*DEPTH.
- Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0]; storage is little-endian.
- Loads:
  - b: sign-extend the selected byte.
  - bu: zero-extend the selected byte.
  - h: sign-extend the half at lane 0 or 2.
  - hu: zero-extend that half.
  - w: the whole word.
- Stores: write only the addressed byte(s) from wdata[7:0], wdata[15:0] or wdata[31:0]; other bytes of the word are preserved.
- Storage is written at most once per request, on the execute edge.
- Requester stalls: a held rsp_ready=0 keeps RESP indefinitely with outputs stable. req_valid asserted outside IDLE is ignored and not latched.
- Reset mid-operation: returns to IDLE the next edge and clears storage. A store in WAIT is discarded; a pending response is dropped.
- Request inputs only need to be valid in the accept cycle.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds outputs rd_count, wr_count and err_count, each 16 bits.
  - Each counter increments on the execute edge of a successful load, successful store or errored request respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; no other behaviour change.

Test Plan:
- Reset, then store word 0xDEADBEEF at addr 0x10 (WAIT_STATES=1) → req_ready low 2 cycles, rsp_valid 2 cycles after accept, rsp_err=0; load w 0x10 → rsp_rdata=0xDEADBEEF.
- After the above, store b 0x5A at addr 0x12 → load w 0x10 returns 0xDE5ABEEF; load b 0x13 returns 0xFFFFFFDE; load bu 0x13 returns 0x000000DE; load h 0x12 returns 0xFFFFDE5A.
- Load w 0x11, store h 0x13, size 011, and addr 0x100 with DEPTH=64 → each rsp_err=1, rsp_rdata=0; word 0x10 is unchanged afterwards.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable; req_valid pulses during that time are not accepted; completes one cycle after rsp_ready=1.
- Assert reset while in WAIT of store 0x11111111 to 0x20 → rsp_valid never rises; after release, load w 0x20 returns 0.
- WAIT_STATES=0 back-to-back loads with rsp_ready=1 → one request per 2 cycles. With DMEM_PERF_CNT_EN, run 3 loads, 2 stores and 1 error → rd_count=3, wr_count=2, err_count=1.
